// File: rtl/jtag_dbg_pkg.sv
// Shared definitions for the Nios II virtual-JTAG debug scan master:
// FSM state encoding, virtual IR opcodes and the default chain length.
package jtag_dbg_pkg;

  localparam int DR_WIDTH_DEF = 38;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RSP  = 3'd6
  } jtag_state_e;

endpackage

// File: rtl/nios2_jtag_debug_scan_master_tck_gen.sv
// TCK divider: low for TCK_DIV clk cycles, high for TCK_DIV cycles, with
// one-cycle strobes on the clk edges that raise and lower TCK.
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic tck_rise_en,
  output logic tck_fall_en
);

  localparam int CW = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(2 * TCK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tck;

  assign tck_rise_en = run && (r_cnt == RISE_AT);
  assign tck_fall_en = run && (r_cnt == FALL_AT);
  assign tck         = r_tck;

  // Counter sits at zero while idle so the first period starts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!run) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else begin
      r_cnt <= tck_fall_en ? '0 : r_cnt + 1'b1;
      if (tck_rise_en)      r_tck <= 1'b1;
      else if (tck_fall_en) r_tck <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_jtag_debug_scan_master.sv
// Virtual-JTAG scan initiator: walks UIR, CDR, SDR x DR_WIDTH, UDR, RTI for
// one command and hands back the captured TDO bits and the sampled IR.
module nios2_jtag_debug_scan_master
  import jtag_dbg_pkg::*;
#(
  parameter int DR_WIDTH   = DR_WIDTH_DEF,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic                cmd_skip_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BCW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int RCW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DR_WIDTH - 1);
  localparam logic [RCW-1:0] RTI_LAST = RCW'(RTI_CYCLES - 1);

  jtag_state_e         r_state;
  jtag_state_e         w_next_state;
  logic [DR_WIDTH-1:0] r_sr;
  logic [BCW-1:0]      r_bit_cnt;
  logic [RCW-1:0]      r_rti_cnt;
  logic [IR_WIDTH-1:0] r_ir_in;
  logic [IR_WIDTH-1:0] r_rsp_ir;
  logic                r_tdi;

  logic w_run;
  logic w_rise;
  logic w_fall;
  logic w_accept;

  assign w_run    = (r_state == ST_UIR) || (r_state == ST_CDR) || (r_state == ST_SDR) ||
                    (r_state == ST_UDR) || (r_state == ST_RTI);
  assign w_accept = (r_state == ST_IDLE) && cmd_valid;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (w_run),
    .tck         (vji_tck),
    .tck_rise_en (w_rise),
    .tck_fall_en (w_fall)
  );

  // Scan states only advance on TCK falling edges, i.e. period boundaries.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_next_state = cmd_skip_ir ? ST_CDR : ST_UIR;
      ST_UIR:  if (w_fall) w_next_state = ST_CDR;
      ST_CDR:  if (w_fall) w_next_state = ST_SDR;
      ST_SDR:  if (w_fall && (r_bit_cnt == BIT_LAST)) w_next_state = ST_UDR;
      ST_UDR:  if (w_fall) w_next_state = ST_RTI;
      ST_RTI:  if (w_fall && (r_rti_cnt == RTI_LAST)) w_next_state = ST_RSP;
      ST_RSP:  if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_rti_cnt <= '0;
      r_ir_in   <= '0;
      r_rsp_ir  <= '0;
      r_tdi     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_sr      <= cmd_data;
        r_bit_cnt <= '0;
        r_rti_cnt <= '0;
        if (!cmd_skip_ir) r_ir_in <= cmd_ir;
      end
      if (w_rise && (r_state == ST_UIR)) r_rsp_ir <= vji_ir_out;
      if (w_rise && (r_state == ST_SDR)) r_sr <= {vji_tdo, r_sr[DR_WIDTH-1:1]};
      // TDI changes only at period boundaries; sr[0] already holds the next bit.
      if (w_fall) begin
        r_tdi <= (w_next_state == ST_SDR) ? r_sr[0] : 1'b0;
        if (r_state == ST_SDR) r_bit_cnt <= r_bit_cnt + 1'b1;
        if (r_state == ST_RTI) r_rti_cnt <= r_rti_cnt + 1'b1;
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RSP);
  assign rsp_data   = rsp_valid ? r_sr : '0;
  assign rsp_ir_out = r_rsp_ir;
  assign vji_tdi    = r_tdi;
  assign vji_ir_in  = r_ir_in;
  assign vji_uir    = (r_state == ST_UIR);
  assign vji_cdr    = (r_state == ST_CDR);
  assign vji_sdr    = (r_state == ST_SDR);
  assign vji_udr    = (r_state == ST_UDR);
  assign vji_rti    = (r_state == ST_IDLE) || (r_state == ST_RTI) || (r_state == ST_RSP);

endmodule

// File: tb/tb_nios2_jtag_debug_scan_master.sv
// Randomized bench for the scan master against a transaction-level model of
// what one command should produce on the virtual-JTAG pins and response port.
module tb_nios2_jtag_debug_scan_master;

  localparam int DR  = 38;
  localparam int IRW = 2;
  localparam int DIV = 2;
  localparam int RTI = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic           cmd_skip_ir = 1'b0;
  logic [DR-1:0]  cmd_data = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DR-1:0]  rsp_data;
  logic [IRW-1:0] rsp_ir_out;
  logic           vji_tck, vji_tdi;
  logic           vji_tdo = 1'b0;
  logic [IRW-1:0] vji_ir_in;
  logic [IRW-1:0] vji_ir_out = '0;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  nios2_jtag_debug_scan_master #(
    .DR_WIDTH(DR), .IR_WIDTH(IRW), .TCK_DIV(DIV), .RTI_CYCLES(RTI)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_skip_ir(cmd_skip_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Pin monitor: counts TCK rises inside SDR, checks TDI against the payload
  // bit for that rise and serves TDO from the current pattern.
  logic [DR-1:0] tdo_pat = '0;
  logic [DR-1:0] exp_tdi = '0;
  int  rise_base = 0;
  int  sdr_rises = 0;
  int  uir_pulses = 0;
  int  tdi_bad = 0;
  int  mk;
  logic prev_tck = 1'b0;
  logic prev_uir = 1'b0;

  always @(posedge clk) begin
    #1;
    mk = sdr_rises - rise_base;
    if (vji_tck && !prev_tck && vji_sdr) begin
      if (mk >= 0 && mk < DR && vji_tdi !== exp_tdi[mk]) tdi_bad++;
      sdr_rises++;
      mk++;
    end
    if (vji_uir && !prev_uir) uir_pulses++;
    vji_tdo  = (mk >= 0 && mk < DR) ? tdo_pat[mk] : 1'b0;
    prev_tck = vji_tck;
    prev_uir = vji_uir;
  end

  // Model state: the IR last loaded and the IR-out last captured.
  logic [IRW-1:0] m_ir_in  = '0;
  logic [IRW-1:0] m_ir_out = '0;

  task automatic chk_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_ir_out", rsp_ir_out, 0);
    chk("rst_tck", vji_tck, 0);
    chk("rst_tdi", vji_tdi, 0);
    chk("rst_ir_in", vji_ir_in, 0);
    chk("rst_levels", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 5'b00001);
  endtask

  task automatic launch(input logic [IRW-1:0] ir, input bit skip, input logic [DR-1:0] data,
                        input logic [DR-1:0] pat, input logic [IRW-1:0] irout, output int t_acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 500) begin @(posedge clk); #1; n++; end
    chk("wait_ready", cmd_ready, 1);
    cmd_ir = ir; cmd_skip_ir = skip; cmd_data = data; vji_ir_out = irout;
    tdo_pat = pat; exp_tdi = data; rise_base = sdr_rises;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t_acc = cyc;
    chk("busy_ready", cmd_ready, 0);
    if (!skip) begin
      m_ir_in  = ir;
      m_ir_out = irout;
    end
  endtask

  task automatic run_cmd(input logic [IRW-1:0] ir, input bit skip, input logic [DR-1:0] data,
                         input logic [DR-1:0] pat, input logic [IRW-1:0] irout, input int hold);
    int t_acc, n, u0, b0, r0;
    u0 = uir_pulses; b0 = tdi_bad; r0 = sdr_rises;
    launch(ir, skip, data, pat, irout, t_acc);
    n = 0;
    while (!rsp_valid && n < 1000) begin @(posedge clk); #1; n++; end
    chk("rsp_arrives", rsp_valid, 1);
    chk("latency", cyc - t_acc, (3 + DR + RTI - (skip ? 1 : 0)) * 2 * DIV);
    chk("sdr_rises", sdr_rises - r0, DR);
    chk("tdi_bits_bad", tdi_bad - b0, 0);
    chk("uir_pulses", uir_pulses - u0, skip ? 0 : 1);
    chk("ir_in", vji_ir_in, m_ir_in);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, pat);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    chk("rsp_data", rsp_data, pat);
    chk("rsp_ir_out", rsp_ir_out, m_ir_out);
    chk("rsp_tck_low", {vji_tck, vji_rti}, 2'b01);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_cmd_ready", cmd_ready, 1);
    chk("hs_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    int t_acc, n, seen;
    logic [DR-1:0] d, p;

    repeat (3) @(posedge clk);
    #2;
    chk_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(2'b10, 1'b0, 38'h2A_AAAA_AAAA, 38'h3F_FFFF_FFFF, 2'b01, 0);
    run_cmd(2'b11, 1'b0, 38'h15_5555_5555, 38'h01_2345_6789, 2'b10, 10);
    d = {$urandom, $urandom};
    p = {$urandom, $urandom};
    run_cmd(2'b00, 1'b1, d, p, 2'b01, 0);

    // Abandon a scan after the 20th shift with an asynchronous reset.
    d = {$urandom, $urandom};
    p = {$urandom, $urandom};
    launch(2'b01, 1'b0, d, p, 2'b11, t_acc);
    n = 0;
    while ((sdr_rises - rise_base) < 20 && n < 1000) begin @(posedge clk); #1; n++; end
    chk("reach_shift20", sdr_rises - rise_base, 20);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset();
    m_ir_in = '0;
    m_ir_out = '0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_reset", seen, 0);

    run_cmd(2'b10, 1'b0, 38'h2A_AAAA_AAAA, 38'h01_2345_6789, 2'b10, 0);

    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom};
      p = {$urandom, $urandom};
      run_cmd(2'($urandom), 1'($urandom), d, p, 2'($urandom), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
